// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide issue controller.
// Op codes, HI/LO write-enable codes and FSM state codes.
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] MD_WE_NONE = 2'b00;
  localparam logic [1:0] MD_WE_HI   = 2'b01;
  localparam logic [1:0] MD_WE_LO   = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } md_state_e;

  // Only mthi/mtlo are real writes; 2'b11 is treated as no write.
  function automatic logic is_mt_write(input logic [1:0] we);
    return (we == MD_WE_HI) || (we == MD_WE_LO);
  endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// md_latency_cnt: loadable 4-bit down-counter for the busy window.
// Clear beats load, load beats decrement; stops at zero.
module md_latency_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clear,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear, load, or step down toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != 4'd0))
      cnt_d = cnt_q - 4'd1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == 4'd1);

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: mult/div issue sequencing, busy window, HI/LO stall.
// Optional perf counters under `MD_PERF_CNT_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_md_start,
  input  logic [1:0] ex_md_op,
  input  logic [1:0] ex_mt_we,
  input  logic       id_md_use,
  input  logic       int_flush,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic [1:0] md_we,
  output logic       md_cancel,
  output logic       md_restore,
  output logic       busy,
  output logic       stall,
  output logic [3:0] remaining
`ifdef MD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_ops
`endif
);

  md_state_e  state_q, state_d;
  logic [1:0] op_q;
  logic       mt_pend_q;
  logic       calc;
  logic       mt_wr;
  logic       accept;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic       cnt_last;

  assign calc  = (state_q == ST_CALC);
  assign mt_wr = is_mt_write(ex_mt_we);

  // A write to HI/LO wins over a start; starts during CALC are dropped.
  assign accept = ex_md_start && !int_flush && !mt_wr && !calc;

  assign load_val = ex_md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  md_latency_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (load_val),
    .clear    (calc && int_flush),
    .dec      (calc),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // Next state plus EX-facing strobes, all forced low during reset.
  always_comb begin
    state_d    = state_q;
    md_start   = 1'b0;
    md_op      = '0;
    md_we      = MD_WE_NONE;
    md_cancel  = 1'b0;
    md_restore = 1'b0;
    stall      = 1'b0;
    if (!reset) begin
      md_start   = accept;
      md_op      = accept ? ex_md_op : op_q;
      md_we      = (mt_wr && !int_flush) ? ex_mt_we : MD_WE_NONE;
      md_cancel  = calc && int_flush;
      md_restore = int_flush && mt_pend_q;
      stall      = id_md_use && (calc || ex_md_start);
      unique case (state_q)
        ST_IDLE: if (accept) state_d = ST_CALC;
        ST_CALC: if (int_flush || cnt_last) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, last accepted op, and one-cycle mthi/mtlo shadow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULT;
      mt_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_pend_q <= mt_wr && !int_flush;
      if (accept)
        op_q <= ex_md_op;
    end
  end

  assign busy      = calc;
  assign remaining = calc ? cnt : 4'd0;

`ifdef MD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] md_ops_q;

  // Free-running stall and issue counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      md_ops_q       <= '0;
    end else begin
      if (stall)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (md_start)
        md_ops_q <= md_ops_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign md_ops       = md_ops_q;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed checks for md_issue_ctrl.
// Define MD_PERF_CNT_EN to also exercise the perf counters.
module tb_md_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_md_start;
  logic [1:0] ex_md_op;
  logic [1:0] ex_mt_we;
  logic       id_md_use;
  logic       int_flush;
  logic       md_start;
  logic [1:0] md_op;
  logic [1:0] md_we;
  logic       md_cancel;
  logic       md_restore;
  logic       busy;
  logic       stall;
  logic [3:0] remaining;
`ifdef MD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] md_ops;
`endif

  int n_chk = 0;
  int n_err = 0;

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_md_start (ex_md_start),
    .ex_md_op    (ex_md_op),
    .ex_mt_we    (ex_mt_we),
    .id_md_use   (id_md_use),
    .int_flush   (int_flush),
    .md_start    (md_start),
    .md_op       (md_op),
    .md_we       (md_we),
    .md_cancel   (md_cancel),
    .md_restore  (md_restore),
    .busy        (busy),
    .stall       (stall),
    .remaining   (remaining)
`ifdef MD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .md_ops      (md_ops)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then let new inputs settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_md_start = 1'b0;
    ex_md_op    = 2'b00;
    ex_mt_we    = 2'b00;
    id_md_use   = 1'b0;
    int_flush   = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rem", 32'(remaining), 0);
    chk("rst_op", 32'(md_op), 0);
    chk("rst_start", 32'(md_start), 0);
    chk("rst_we", 32'(md_we), 0);
    chk("rst_cancel", 32'(md_cancel), 0);
    chk("rst_restore", 32'(md_restore), 0);

    // mult with a consumer stalled throughout
    ex_md_start = 1'b1;
    ex_md_op    = 2'b00;
    id_md_use   = 1'b1;
    settle();
    chk("mul_start", 32'(md_start), 1);
    chk("mul_stall0", 32'(stall), 1);
    chk("mul_busy0", 32'(busy), 0);
    tick();
    ex_md_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      settle();
      chk("mul_busy", 32'(busy), 1);
      chk("mul_stall", 32'(stall), 1);
      chk("mul_rem", 32'(remaining), 32'(6 - i));
      chk("mul_nostart", 32'(md_start), 0);
      tick();
    end
    settle();
    chk("mul_done_busy", 32'(busy), 0);
    chk("mul_done_stall", 32'(stall), 0);
    chk("mul_done_rem", 32'(remaining), 0);
    idle_in();

    // divu: 10 busy cycles; stray start mid-calc is ignored
    ex_md_start = 1'b1;
    ex_md_op    = 2'b11;
    settle();
    chk("divu_start", 32'(md_start), 1);
    chk("divu_op", 32'(md_op), 3);
    tick();
    ex_md_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) begin
        ex_md_start = 1'b1;
        ex_md_op    = 2'b00;
      end else begin
        ex_md_start = 1'b0;
      end
      settle();
      chk("divu_busy", 32'(busy), 1);
      chk("divu_rem", 32'(remaining), 32'(11 - i));
      chk("divu_op_hold", 32'(md_op), 3);
      if (i == 2)
        chk("divu_stray_start", 32'(md_start), 0);
      tick();
    end
    ex_md_start = 1'b1;
    ex_md_op    = 2'b11;
    settle();
    chk("divu2_idle", 32'(busy), 0);
    chk("divu2_start", 32'(md_start), 1);
    tick();
    ex_md_start = 1'b0;
    settle();
    chk("divu2_rem", 32'(remaining), 10);
    for (int i = 0; i < 10; i++) tick();
    chk("divu2_done", 32'(busy), 0);

    // div cancelled by a flush at busy cycle 3
    ex_md_start = 1'b1;
    ex_md_op    = 2'b10;
    id_md_use   = 1'b1;
    tick();
    ex_md_start = 1'b0;
    tick();
    tick();
    int_flush = 1'b1;
    settle();
    chk("cxl_cancel", 32'(md_cancel), 1);
    chk("cxl_rem3", 32'(remaining), 8);
    chk("cxl_restore", 32'(md_restore), 0);
    tick();
    int_flush = 1'b0;
    settle();
    chk("cxl_busy", 32'(busy), 0);
    chk("cxl_rem", 32'(remaining), 0);
    chk("cxl_stall", 32'(stall), 0);
    chk("cxl_cancel_off", 32'(md_cancel), 0);
    idle_in();

    // mthi then flush next cycle restores HI/LO
    ex_mt_we = 2'b01;
    settle();
    chk("mthi_we", 32'(md_we), 1);
    chk("mthi_nostart", 32'(md_start), 0);
    tick();
    ex_mt_we  = 2'b00;
    int_flush = 1'b1;
    settle();
    chk("mthi_restore", 32'(md_restore), 1);
    chk("mthi_nocancel", 32'(md_cancel), 0);
    tick();
    int_flush = 1'b0;

    // mtlo then flush two cycles later: no restore
    ex_mt_we = 2'b10;
    tick();
    ex_mt_we = 2'b00;
    settle();
    chk("mtlo_c1_restore", 32'(md_restore), 0);
    tick();
    int_flush = 1'b1;
    settle();
    chk("mtlo_c2_restore", 32'(md_restore), 0);
    tick();

    // mthi flushed in its own cycle: write suppressed
    ex_mt_we  = 2'b01;
    int_flush = 1'b1;
    settle();
    chk("mthi_flushed_we", 32'(md_we), 0);
    tick();
    idle_in();

    // start and mtlo together: the write wins
    ex_md_start = 1'b1;
    ex_md_op    = 2'b01;
    ex_mt_we    = 2'b10;
    settle();
    chk("both_we", 32'(md_we), 2);
    chk("both_start", 32'(md_start), 0);
    chk("both_op", 32'(md_op), 2);
    tick();
    idle_in();
    settle();
    chk("both_idle", 32'(busy), 0);

    // reset in the middle of a multu
    ex_md_start = 1'b1;
    ex_md_op    = 2'b01;
    tick();
    ex_md_start = 1'b0;
    tick();
    chk("rstmid_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_rem", 32'(remaining), 0);
    chk("rstmid_op", 32'(md_op), 0);
    chk("rstmid_cancel", 32'(md_cancel), 0);
    reset = 1'b0;
    settle();
    chk("rstmid_post_busy", 32'(busy), 0);
    chk("rstmid_post_op", 32'(md_op), 0);

`ifdef MD_PERF_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("perf_rst_ops", md_ops, 0);
    chk("perf_rst_stall", stall_cycles, 0);
    for (int k = 0; k < 2; k++) begin
      ex_md_start = 1'b1;
      ex_md_op    = 2'b00;
      id_md_use   = 1'b1;
      tick();
      ex_md_start = 1'b0;
      tick();
      tick();
      id_md_use = 1'b0;
      for (int i = 0; i < 5; i++) tick();
    end
    chk("perf_ops", md_ops, 2);
    chk("perf_stall", stall_cycles, 6);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
